alu_integrity_monitor: RTL and testbench

- Runtime checker at the consuming end of the 4-bit ALU interface (A, B, op → result, carry, zero, overflow).
- Snoops every qualified ALU transaction and recomputes the golden result internally.
- Compares the golden result with the observed ALU outputs and escalates repeated mismatches through a suspicion state machine into a sticky alarm.
- Instantiated beside the ALU wrapper whichever implementation variant is compiled in, so an inserted trojan's payload is flagged at run time.

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_golden_model.sv | 23 ++
 rtl/alu_integrity_monitor.sv | 156 +++++++++++++++
 tb/tb_alu_integrity_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, monitor state encoding and the golden ALU function.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MONITOR = 2'd1,
      ST_SUSPECT = 2'd2,
      ST_ALARM   = 2'd3
   } mon_state_t;

   typedef struct packed {
      logic [3:0] result;
      logic       carry;
      logic       zero;
      logic       overflow;
   } alu_out_t;

   // One snooped transaction plus its golden outputs, as carried down the delay line.
   typedef struct packed {
      logic       valid;
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
      alu_out_t   gold;
   } cmp_entry_t;

   function automatic alu_out_t alu_golden(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
      alu_out_t   o;
      logic [4:0] sum;
      o   = '0;
      sum = '0;
      case (op)
         OP_ADD: begin
            sum        = {1'b0, a} + {1'b0, b};
            o.result   = sum[3:0];
            o.carry    = sum[4];
            o.overflow = (a[3] == b[3]) && (sum[3] != a[3]);
         end
         OP_SUB: begin
            sum        = {1'b0, a} - {1'b0, b};
            o.result   = sum[3:0];
            o.carry    = (a < b);
            o.overflow = (a[3] != b[3]) && (sum[3] != a[3]);
         end
         OP_AND:  o.result = a & b;
         default: o.result = a | b;
      endcase
      o.zero = (o.result == 4'd0);
      return o;
   endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference ALU wrapping the package golden function.
module alu_golden_model
   import alu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [1:0] op,
   output logic [3:0] result,
   output logic       carry,
   output logic       zero,
   output logic       overflow
);

   alu_out_t gold;

   always_comb gold = alu_golden(a, b, op);

   assign result   = gold.result;
   assign carry    = gold.carry;
   assign zero     = gold.zero;
   assign overflow = gold.overflow;

endmodule

// File: rtl/alu_integrity_monitor.sv
// Runtime ALU checker: recomputes each snooped op, compares against observed outputs after
// DUT_LATENCY cycles, and escalates repeated mismatches to a sticky alarm.
module alu_integrity_monitor
   import alu_pkg::*;
#(
   parameter int DUT_LATENCY = 0,
   parameter int THRESH      = 3,
   parameter int WINDOW      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clear,
   input  logic       obs_valid,
   input  logic [3:0] obs_a,
   input  logic [3:0] obs_b,
   input  logic [1:0] obs_op,
   input  logic [3:0] obs_result,
   input  logic       obs_carry,
   input  logic       obs_zero,
   input  logic       obs_overflow,
   output logic       mismatch,
   output logic       alarm,
   output logic [7:0] err_count,
   output logic [1:0] mon_state,
   output logic [1:0] fail_op,
   output logic [3:0] fail_a,
   output logic [3:0] fail_b
);

   cmp_entry_t live, dly;
   mon_state_t state_reg;
   logic       mismatch_reg;
   logic [7:0] err_count_reg;
   logic [3:0] hit_cnt_reg;
   logic [7:0] win_cnt_reg;
   logic       fail_latched_reg;
   logic [1:0] fail_op_reg;
   logic [3:0] fail_a_reg, fail_b_reg;
   logic       active, differ, hit, count_hit;

   assign live.valid = obs_valid;
   assign live.op    = obs_op;
   assign live.a     = obs_a;
   assign live.b     = obs_b;

   alu_golden_model u_golden (
      .a        (obs_a),
      .b        (obs_b),
      .op       (obs_op),
      .result   (live.gold.result),
      .carry    (live.gold.carry),
      .zero     (live.gold.zero),
      .overflow (live.gold.overflow)
   );

   generate
      if (DUT_LATENCY == 0) begin : g_no_delay
         assign dly = live;
      end else begin : g_delay
         cmp_entry_t stage_reg [DUT_LATENCY];
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < DUT_LATENCY; i++) stage_reg[i] <= '0;
            end else begin
               stage_reg[0] <= live;
               for (int i = 1; i < DUT_LATENCY; i++) stage_reg[i] <= stage_reg[i-1];
            end
         end
         assign dly = stage_reg[DUT_LATENCY-1];
      end
   endgenerate

   // ALARM keeps comparing regardless of en; IDLE never compares.
   assign active    = dly.valid && ((state_reg == ST_ALARM) ||
                      (en && (state_reg == ST_MONITOR || state_reg == ST_SUSPECT)));
   assign differ    = {obs_result, obs_carry, obs_zero, obs_overflow} != dly.gold;
   assign hit       = active && differ;
   assign count_hit = hit && !clear;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= ST_IDLE;
         mismatch_reg     <= 1'b0;
         err_count_reg    <= '0;
         hit_cnt_reg      <= '0;
         win_cnt_reg      <= '0;
         fail_latched_reg <= 1'b0;
         fail_op_reg      <= '0;
         fail_a_reg       <= '0;
         fail_b_reg       <= '0;
      end else begin
         mismatch_reg <= hit;
         if (count_hit) begin
            if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
            if (!fail_latched_reg) begin
               fail_latched_reg <= 1'b1;
               fail_op_reg      <= dly.op;
               fail_a_reg       <= dly.a;
               fail_b_reg       <= dly.b;
            end
         end
         case (state_reg)
            ST_IDLE: if (en) state_reg <= ST_MONITOR;
            ST_MONITOR: begin
               if (!en) begin
                  state_reg   <= ST_IDLE;
                  win_cnt_reg <= '0;
               end else if (count_hit) begin
                  state_reg   <= (THRESH == 1) ? ST_ALARM : ST_SUSPECT;
                  hit_cnt_reg <= 4'd1;
                  win_cnt_reg <= '0;
               end
            end
            ST_SUSPECT: begin
               if (!en) begin
                  state_reg   <= ST_IDLE;
                  win_cnt_reg <= '0;
               end else if (active && !clear) begin
                  if (differ) begin
                     hit_cnt_reg <= hit_cnt_reg + 4'd1;
                     win_cnt_reg <= '0;
                     if ({1'b0, hit_cnt_reg} + 5'd1 >= 5'(THRESH)) state_reg <= ST_ALARM;
                  end else if ({1'b0, win_cnt_reg} + 9'd1 >= 9'(WINDOW)) begin
                     state_reg   <= ST_MONITOR;
                     hit_cnt_reg <= '0;
                     win_cnt_reg <= '0;
                  end else begin
                     win_cnt_reg <= win_cnt_reg + 8'd1;
                  end
               end
            end
            default: if (clear) state_reg <= ST_IDLE;
         endcase
         // clear overrides any counting or latching done above in this cycle.
         if (clear) begin
            err_count_reg    <= '0;
            hit_cnt_reg      <= '0;
            win_cnt_reg      <= '0;
            fail_latched_reg <= 1'b0;
            fail_op_reg      <= '0;
            fail_a_reg       <= '0;
            fail_b_reg       <= '0;
         end
      end
   end

   assign mismatch  = mismatch_reg;
   assign alarm     = (state_reg == ST_ALARM);
   assign err_count = err_count_reg;
   assign mon_state = state_reg;
   assign fail_op   = fail_op_reg;
   assign fail_a    = fail_a_reg;
   assign fail_b    = fail_b_reg;

endmodule

// File: tb/tb_alu_integrity_monitor.sv
// Directed bench: latency-0 monitor checked through a mismatch scoreboard, plus a
// latency-2 monitor fed a clean, two-cycle-delayed ALU that must never flag.
module tb_alu_integrity_monitor;

   logic       clk = 1'b0;
   logic       rst_n, en, clear, obs_valid;
   logic [3:0] obs_a, obs_b, obs_result;
   logic [1:0] obs_op;
   logic       obs_carry, obs_zero, obs_overflow;

   logic       mismatch, alarm;
   logic [7:0] err_count;
   logic [1:0] mon_state, fail_op;
   logic [3:0] fail_a, fail_b;

   logic       d2_mismatch, d2_alarm;
   logic [7:0] d2_err;
   logic [1:0] d2_state, d2_fop;
   logic [3:0] d2_fa, d2_fb;

   logic [6:0] g_now, g_d1, g_d2;
   int         tests = 0;
   int         fails = 0;
   int         d2_mm_cnt = 0;
   bit         exp_q[$];

   always #5 clk = ~clk;

   // Reference ALU using signed-range arithmetic: returns {result, carry, zero, overflow}.
   function automatic logic [6:0] tb_golden(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
      int ua, ub, sa, sb, r, s;
      logic c, v;
      logic [3:0] res;
      ua = int'(a); ub = int'(b);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      c = 1'b0; v = 1'b0; r = 0;
      case (op)
         2'b00: begin r = ua + ub; c = (r > 15); s = sa + sb; v = (s > 7) || (s < -8); end
         2'b01: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 7) || (s < -8); end
         2'b10: r = int'(a & b);
         default: r = int'(a | b);
      endcase
      res = r[3:0];
      return {res, c, (res == 4'd0), v};
   endfunction

   assign g_now = tb_golden(obs_a, obs_b, obs_op);
   always @(posedge clk) begin
      g_d1 <= g_now;
      g_d2 <= g_d1;
   end

   alu_integrity_monitor #(.DUT_LATENCY(0), .THRESH(3), .WINDOW(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .obs_valid(obs_valid),
      .obs_a(obs_a), .obs_b(obs_b), .obs_op(obs_op), .obs_result(obs_result),
      .obs_carry(obs_carry), .obs_zero(obs_zero), .obs_overflow(obs_overflow),
      .mismatch(mismatch), .alarm(alarm), .err_count(err_count), .mon_state(mon_state),
      .fail_op(fail_op), .fail_a(fail_a), .fail_b(fail_b)
   );

   alu_integrity_monitor #(.DUT_LATENCY(2), .THRESH(3), .WINDOW(16)) dut_lat2 (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .obs_valid(obs_valid),
      .obs_a(obs_a), .obs_b(obs_b), .obs_op(obs_op), .obs_result(g_d2[6:3]),
      .obs_carry(g_d2[2]), .obs_zero(g_d2[1]), .obs_overflow(g_d2[0]),
      .mismatch(d2_mismatch), .alarm(d2_alarm), .err_count(d2_err), .mon_state(d2_state),
      .fail_op(d2_fop), .fail_a(d2_fa), .fail_b(d2_fb)
   );

   always @(negedge clk) if (d2_mismatch !== 1'b0) d2_mm_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   // One valid op; rx/cx/vx corrupt the observed result, carry and overflow.
   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic [3:0] rx, input logic cx, input logic vx, input logic act);
      logic [6:0] g;
      g = tb_golden(a, b, op);
      obs_valid = 1'b1; obs_a = a; obs_b = b; obs_op = op;
      obs_result = g[6:3] ^ rx; obs_carry = g[2] ^ cx; obs_zero = g[1]; obs_overflow = g[0] ^ vx;
      exp_q.push_back(act && (rx != 4'd0 || cx || vx));
      @(posedge clk); #1;
      obs_valid = 1'b0;
      chk("mismatch", {31'd0, mismatch}, {31'd0, exp_q.pop_front()});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mismatch"}, {31'd0, mismatch}, 0);
      chk({tag, "_alarm"}, {31'd0, alarm}, 0);
      chk({tag, "_err"}, {24'd0, err_count}, 0);
      chk({tag, "_state"}, {30'd0, mon_state}, 0);
      chk({tag, "_fail_op"}, {30'd0, fail_op}, 0);
      chk({tag, "_fail_a"}, {28'd0, fail_a}, 0);
      chk({tag, "_fail_b"}, {28'd0, fail_b}, 0);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clear = 1'b0; obs_valid = 1'b0;
      obs_a = '0; obs_b = '0; obs_op = '0;
      obs_result = '0; obs_carry = 1'b0; obs_zero = 1'b1; obs_overflow = 1'b0;
      idle(); idle();
      chk_all_zero("reset");
      rst_n = 1'b1;
      idle();
      chk("idle_no_en", {30'd0, mon_state}, 0);
      en = 1'b1;
      idle();
      chk("enter_monitor", {30'd0, mon_state}, 1);

      for (int i = 0; i < 256; i++)
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)), 4'd0, 1'b0, 1'b0, 1'b1);
      chk("clean_alarm", {31'd0, alarm}, 0);
      chk("clean_state", {30'd0, mon_state}, 1);
      chk("clean_err", {24'd0, err_count}, 0);
      chk("lat2_clean_state", {30'd0, d2_state}, 1);

      // 7 + 1 = 8, observed as 9
      drive(4'h7, 4'h1, 2'b00, 4'h1, 1'b0, 1'b0, 1'b1);
      chk("single_err", {24'd0, err_count}, 1);
      chk("single_state", {30'd0, mon_state}, 2);
      chk("single_fail_a", {28'd0, fail_a}, 7);
      chk("single_fail_b", {28'd0, fail_b}, 1);
      chk("single_fail_op", {30'd0, fail_op}, 0);

      for (int i = 0; i < 15; i++) drive(4'(i), 4'h3, 2'b10, 4'd0, 1'b0, 1'b0, 1'b1);
      chk("window_not_yet", {30'd0, mon_state}, 2);
      drive(4'h9, 4'h6, 2'b11, 4'd0, 1'b0, 1'b0, 1'b1);
      chk("window_expired", {30'd0, mon_state}, 1);

      drive(4'h2, 4'h2, 2'b00, 4'h8, 1'b0, 1'b0, 1'b1);
      chk("reenter_suspect", {30'd0, mon_state}, 2);
      chk("fail_hold_a", {28'd0, fail_a}, 7);
      drive(4'h1, 4'h1, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
      drive(4'hC, 4'h5, 2'b10, 4'h2, 1'b0, 1'b0, 1'b1);
      chk("second_hit_state", {30'd0, mon_state}, 2);
      chk("second_hit_alarm", {31'd0, alarm}, 0);
      drive(4'h1, 4'h1, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
      drive(4'h3, 4'hA, 2'b01, 4'h4, 1'b0, 1'b0, 1'b1);
      chk("third_hit_alarm", {31'd0, alarm}, 1);
      chk("third_hit_state", {30'd0, mon_state}, 3);
      chk("third_hit_err", {24'd0, err_count}, 4);

      // 8 - 1 overflows (golden 1); 2 - 5 borrows (golden carry 1)
      drive(4'h8, 4'h1, 2'b01, 4'd0, 1'b0, 1'b1, 1'b1);
      drive(4'h2, 4'h5, 2'b01, 4'd0, 1'b1, 1'b0, 1'b1);
      chk("flags_err", {24'd0, err_count}, 6);
      drive(4'h8, 4'h1, 2'b01, 4'd0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 250; i++) drive(4'(i), 4'h0, 2'b11, 4'h5, 1'b0, 1'b0, 1'b1);
      chk("err_saturate", {24'd0, err_count}, 255);

      en = 1'b0;
      idle();
      chk("alarm_sticky", {31'd0, alarm}, 1);
      chk("alarm_state_en0", {30'd0, mon_state}, 3);
      drive(4'hF, 4'h1, 2'b00, 4'h1, 1'b0, 1'b0, 1'b1);
      chk("err_no_wrap", {24'd0, err_count}, 255);

      clear = 1'b1;
      drive(4'h4, 4'h4, 2'b10, 4'h1, 1'b0, 1'b0, 1'b1);
      clear = 1'b0;
      chk("clear_alarm", {31'd0, alarm}, 0);
      chk("clear_state", {30'd0, mon_state}, 0);
      chk("clear_err", {24'd0, err_count}, 0);
      chk("clear_fail_a", {28'd0, fail_a}, 0);

      drive(4'h4, 4'h4, 2'b10, 4'h1, 1'b0, 1'b0, 1'b0);
      chk("idle_err", {24'd0, err_count}, 0);

      en = 1'b1;
      idle();
      clear = 1'b1;
      drive(4'h6, 4'h6, 2'b00, 4'h3, 1'b0, 1'b0, 1'b1);
      clear = 1'b0;
      chk("clear_wins_state", {30'd0, mon_state}, 1);
      chk("clear_wins_err", {24'd0, err_count}, 0);
      drive(4'h3, 4'h4, 2'b11, 4'h1, 1'b0, 1'b0, 1'b1);
      chk("relatch_state", {30'd0, mon_state}, 2);
      chk("relatch_fail_op", {30'd0, fail_op}, 3);
      chk("relatch_fail_a", {28'd0, fail_a}, 3);
      chk("relatch_fail_b", {28'd0, fail_b}, 4);
      en = 1'b0;
      idle();
      chk("suspect_to_idle", {30'd0, mon_state}, 0);
      chk("idle_err_hold", {24'd0, err_count}, 1);

      en = 1'b1;
      idle();
      obs_valid = 1'b1; obs_a = 4'h5; obs_b = 4'h5; obs_op = 2'b00;
      obs_result = 4'hF; obs_carry = 1'b0; obs_zero = 1'b0; obs_overflow = 1'b1;
      rst_n = 1'b0;
      idle();
      obs_valid = 1'b0;
      chk_all_zero("mid_reset");
      rst_n = 1'b1;
      idle(); idle(); idle();
      chk("post_reset_mismatch", {31'd0, mismatch}, 0);
      chk("post_reset_err", {24'd0, err_count}, 0);

      chk("lat2_no_false_mismatch", d2_mm_cnt, 0);
      chk("lat2_alarm", {31'd0, d2_alarm}, 0);
      chk("lat2_err", {24'd0, d2_err}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
